// File: rtl/regop_pkg.sv
// Shared types and default sizes for the register-operation sequencer.
package regop_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLT = 3'd5,
      OP_MOV = 3'd6,
      OP_CMP = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE,
      S_RESP
   } state_e;

   // CMP produces a response only; every other op updates rd.
   function automatic logic op_writes(input op_e op);
      return op != OP_CMP;
   endfunction

endpackage

// File: rtl/regop_alu.sv
// Combinational ALU: all arithmetic wraps modulo 2^DATA_W, SLT is signed.
module regop_alu
   import regop_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  op_e               op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_MOV:  result = a;
         OP_CMP:  result = a - b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/reg_op_sequencer.sv
// Sequences one register-file command at a time: read operands, execute,
// write back, then hold the response until it is taken.
module reg_op_sequencer
   import regop_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   output logic [ADDR_W-1:0] A1,
   output logic [ADDR_W-1:0] A2,
   input  logic [DATA_W-1:0] RD1,
   input  logic [DATA_W-1:0] RD2,
   output logic [ADDR_W-1:0] A3,
   output logic [DATA_W-1:0] WD3,
   output logic              WE,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zero
);

   state_e            state, state_n;
   op_e               op_q, op_n;
   logic [ADDR_W-1:0] rd_q, rd_n;
   logic [ADDR_W-1:0] a1_n, a2_n, a3_n;
   logic [DATA_W-1:0] wd3_n, rsp_data_n;
   logic              we_n, rsp_zero_n;
   logic              out_of_reset;
   logic              accept;
   logic [DATA_W-1:0] alu_result;

   regop_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op_q),
      .a      (RD1),
      .b      (RD2),
      .result (alu_result)
   );

   // Ready is held low while reset is asserted, even though state is IDLE.
   assign cmd_ready = out_of_reset && (state == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign rsp_valid = (state == S_WRITE) || (state == S_RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         out_of_reset <= 1'b0;
         op_q         <= OP_ADD;
         rd_q         <= '0;
         A1           <= '0;
         A2           <= '0;
         A3           <= '0;
         WD3          <= '0;
         WE           <= 1'b0;
         rsp_data     <= '0;
         rsp_zero     <= 1'b0;
      end else begin
         state        <= state_n;
         out_of_reset <= 1'b1;
         op_q         <= op_n;
         rd_q         <= rd_n;
         A1           <= a1_n;
         A2           <= a2_n;
         A3           <= a3_n;
         WD3          <= wd3_n;
         WE           <= we_n;
         rsp_data     <= rsp_data_n;
         rsp_zero     <= rsp_zero_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (accept) state_n = S_READ;
         S_READ:  state_n = S_EXEC;
         S_EXEC:  state_n = S_WRITE;
         S_WRITE: state_n = rsp_ready ? S_IDLE : S_RESP;
         S_RESP:  if (rsp_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      op_n       = op_q;
      rd_n       = rd_q;
      a1_n       = A1;
      a2_n       = A2;
      a3_n       = A3;
      wd3_n      = WD3;
      we_n       = 1'b0;
      rsp_data_n = rsp_data;
      rsp_zero_n = rsp_zero;
      case (state)
         S_IDLE: begin
            if (accept) begin
               op_n = op_e'(cmd_op);
               rd_n = cmd_rd;
               a1_n = cmd_rs1;
               a2_n = cmd_rs2;
            end
         end
         S_EXEC: begin
            wd3_n      = alu_result;
            a3_n       = rd_q;
            we_n       = op_writes(op_q);
            rsp_data_n = alu_result;
            rsp_zero_n = (alu_result == '0);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a 16x32 synchronous-read register file.
module tb_reg_op_sequencer;
   import regop_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_op;
   logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
   logic [AW-1:0] A1, A2, A3;
   logic [DW-1:0] RD1, RD2, WD3;
   logic          WE;
   logic          rsp_valid, rsp_ready, rsp_zero;
   logic [DW-1:0] rsp_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reg_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_rd    (cmd_rd),
      .cmd_rs1   (cmd_rs1),
      .cmd_rs2   (cmd_rs2),
      .A1        (A1),
      .A2        (A2),
      .RD1       (RD1),
      .RD2       (RD2),
      .A3        (A3),
      .WD3       (WD3),
      .WE        (WE),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero)
   );

   // Register file: loaded with r[i] = i, not touched by the sequencer reset.
   logic [DW-1:0] regs [16];
   logic          rf_load;
   int            we_count;

   always @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 16; i++) regs[i] <= DW'(i);
         we_count <= 0;
      end else begin
         if (WE) begin
            regs[A3] <= WD3;
            we_count <= we_count + 1;
         end
      end
      RD1 <= regs[A1];
      RD2 <= regs[A2];
   end

   typedef struct {
      op_e           op;
      logic [AW-1:0] rd;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [DW-1:0] res;
      logic          zero;
      logic          we;
      logic [DW-1:0] reg_after;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_A1"}, A1, 0);
      check({tag, "_A2"}, A2, 0);
      check({tag, "_A3"}, A3, 0);
      check({tag, "_WD3"}, WD3, 0);
      check({tag, "_WE"}, WE, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_rsp_zero"}, rsp_zero, 0);
      check({tag, "_cmd_ready"}, cmd_ready, 0);
   endtask

   // Entered at posedge+1 with the sequencer idle and rsp_ready high.
   task automatic run_vec(input vec_t v, input int idx);
      check($sformatf("v%0d_ready", idx), cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_rd    = v.rd;
      cmd_rs1   = v.rs1;
      cmd_rs2   = v.rs2;
      tick();
      cmd_valid = 1'b0;
      check($sformatf("v%0d_A1", idx), A1, v.rs1);
      check($sformatf("v%0d_A2", idx), A2, v.rs2);
      check($sformatf("v%0d_busy", idx), cmd_ready, 0);
      tick();
      check($sformatf("v%0d_we_early", idx), WE, 0);
      tick();
      check($sformatf("v%0d_WE", idx), WE, v.we);
      check($sformatf("v%0d_A3", idx), A3, v.rd);
      check($sformatf("v%0d_WD3", idx), WD3, v.res);
      check($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
      check($sformatf("v%0d_rsp_data", idx), rsp_data, v.res);
      check($sformatf("v%0d_rsp_zero", idx), rsp_zero, v.zero);
      tick();
      check($sformatf("v%0d_we_off", idx), WE, 0);
      check($sformatf("v%0d_rsp_done", idx), rsp_valid, 0);
      check($sformatf("v%0d_reg", idx), regs[v.rd], v.reg_after);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      vec_t v;

      vecs[0]  = '{OP_ADD, 4'd5,  4'd3,  4'd4,  32'h0000_0007, 1'b0, 1'b1, 32'h0000_0007};
      vecs[1]  = '{OP_SUB, 4'd6,  4'd2,  4'd3,  32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF};
      vecs[2]  = '{OP_MOV, 4'd7,  4'd6,  4'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF};
      vecs[3]  = '{OP_CMP, 4'd9,  4'd9,  4'd9,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0009};
      vecs[4]  = '{OP_SLT, 4'd10, 4'd7,  4'd1,  32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001};
      vecs[5]  = '{OP_SLT, 4'd11, 4'd1,  4'd7,  32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000};
      vecs[6]  = '{OP_ADD, 4'd2,  4'd2,  4'd2,  32'h0000_0004, 1'b0, 1'b1, 32'h0000_0004};
      vecs[7]  = '{OP_AND, 4'd12, 4'd5,  4'd12, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0004};
      vecs[8]  = '{OP_OR,  4'd13, 4'd13, 4'd3,  32'h0000_000F, 1'b0, 1'b1, 32'h0000_000F};
      vecs[9]  = '{OP_XOR, 4'd14, 4'd14, 4'd7,  32'hFFFF_FFF1, 1'b0, 1'b1, 32'hFFFF_FFF1};
      vecs[10] = '{OP_ADD, 4'd0,  4'd15, 4'd1,  32'h0000_0010, 1'b0, 1'b1, 32'h0000_0010};
      vecs[11] = '{OP_ADD, 4'd15, 4'd7,  4'd1,  32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000};
      vecs[12] = '{OP_MOV, 4'd1,  4'd0,  4'd0,  32'h0000_0010, 1'b0, 1'b1, 32'h0000_0010};
      vecs[13] = '{OP_CMP, 4'd3,  4'd5,  4'd6,  32'h0000_0008, 1'b0, 1'b0, 32'h0000_0003};

      rst_n     = 1'b0;
      rf_load   = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_rd    = '0;
      cmd_rs1   = '0;
      cmd_rs2   = '0;
      rsp_ready = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      rf_load = 1'b0;
      rst_n   = 1'b1;
      tick();
      check("ready_after_reset", cmd_ready, 1);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Back-pressure: response held for 5 cycles, busy-time commands ignored.
      w0        = we_count;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_rd    = 4'd1;
      cmd_rs1   = 4'd1;
      cmd_rs2   = 4'd3;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      check("bp_WE", WE, 1);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 32'd19);
      cmd_valid = 1'b1;
      cmd_op    = OP_SUB;
      cmd_rd    = 4'd1;
      cmd_rs1   = 4'd0;
      cmd_rs2   = 4'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_hold%0d_valid", i), rsp_valid, 1);
         check($sformatf("bp_hold%0d_data", i), rsp_data, 32'd19);
         check($sformatf("bp_hold%0d_zero", i), rsp_zero, 0);
         check($sformatf("bp_hold%0d_ready", i), cmd_ready, 0);
         check($sformatf("bp_hold%0d_WE", i), WE, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      check("bp_done_valid", rsp_valid, 0);
      check("bp_done_ready", cmd_ready, 1);
      check("bp_we_pulses", we_count - w0, 1);
      check("bp_r1", regs[1], 32'd19);

      // Reset pulse while the ADD to r8 sits in EXEC.
      w0        = we_count;
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_rd    = 4'd8;
      cmd_rs1   = 4'd3;
      cmd_rs2   = 4'd4;
      tick();
      cmd_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      tick();
      tick();
      check_all_zero("midrst_hold");
      rst_n = 1'b1;
      tick();
      check("midrst_no_we", we_count - w0, 0);
      check("midrst_r8", regs[8], 32'd8);
      check("midrst_ready", cmd_ready, 1);
      v = '{OP_ADD, 4'd8, 4'd3, 4'd4, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0007};
      run_vec(v, 99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
